// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access, with branch squash and access timeout.
// Optional ARB_STATS_EN macro adds saturating completion/stall counters.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_taken,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_freeze,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_freeze,
    output logic              bus_err,
`ifdef ARB_STATS_EN
    output logic [31:0]       stat_if_cnt,
    output logic [31:0]       stat_mem_cnt,
    output logic [31:0]       stat_stall_cnt,
`endif
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
);

    localparam int unsigned TCNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IF_ACC  = 2'd1,
        S_MEM_ACC = 2'd2,
        S_IF_DROP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_m_req;
    logic                r_m_we;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [DATA_W-1:0]   r_m_wdata;
    logic                r_if_ready;
    logic [DATA_W-1:0]   r_if_rdata;
    logic                r_mem_ready;
    logic [DATA_W-1:0]   r_mem_rdata;
    logic                r_bus_err;
    logic [TCNT_W-1:0]   r_tcnt;

    logic                w_m_req_nxt;
    logic                w_m_we_nxt;
    logic [ADDR_W-1:0]   w_m_addr_nxt;
    logic [DATA_W-1:0]   w_m_wdata_nxt;
    logic                w_if_ready_nxt;
    logic [DATA_W-1:0]   w_if_rdata_nxt;
    logic                w_mem_ready_nxt;
    logic [DATA_W-1:0]   w_mem_rdata_nxt;
    logic                w_bus_err_nxt;
    logic [TCNT_W-1:0]   w_tcnt_nxt;

    logic                w_mem_elig;
    logic                w_if_elig;
    logic                w_timeout;

    // A requester still holds its req during its own ready cycle; don't re-grant it then.
    assign w_mem_elig = mem_req & ~r_mem_ready;
    assign w_if_elig  = if_req  & ~r_if_ready;
    // Abort once m_req has been held TIMEOUT cycles without an ack; an ack in the last cycle still wins.
    assign w_timeout  = ~m_ack & (r_tcnt == TCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_m_req_nxt     = r_m_req;
        w_m_we_nxt      = r_m_we;
        w_m_addr_nxt    = r_m_addr;
        w_m_wdata_nxt   = r_m_wdata;
        w_if_ready_nxt  = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_mem_ready_nxt = 1'b0;
        w_mem_rdata_nxt = r_mem_rdata;
        w_bus_err_nxt   = 1'b0;
        w_tcnt_nxt      = r_tcnt;

        case (r_state)
            S_IDLE: begin
                if (w_mem_elig) begin
                    w_state_nxt   = S_MEM_ACC;
                    w_m_req_nxt   = 1'b1;
                    w_m_we_nxt    = mem_we;
                    w_m_addr_nxt  = mem_addr;
                    w_m_wdata_nxt = mem_wdata;
                    w_tcnt_nxt    = '0;
                end else if (w_if_elig) begin
                    w_state_nxt   = S_IF_ACC;
                    w_m_req_nxt   = 1'b1;
                    w_m_we_nxt    = 1'b0;
                    w_m_addr_nxt  = if_addr;
                    w_m_wdata_nxt = '0;
                    w_tcnt_nxt    = '0;
                end
            end
            S_IF_ACC: begin
                if (m_ack) begin
                    w_state_nxt = S_IDLE;
                    w_m_req_nxt = 1'b0;
                    if (!branch_taken) begin
                        w_if_ready_nxt = 1'b1;
                        w_if_rdata_nxt = m_rdata;
                    end
                end else if (w_timeout) begin
                    w_state_nxt   = S_IDLE;
                    w_m_req_nxt   = 1'b0;
                    w_bus_err_nxt = 1'b1;
                    if (!branch_taken) begin
                        w_if_ready_nxt = 1'b1;
                        w_if_rdata_nxt = '0;
                    end
                end else begin
                    w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                    if (branch_taken) begin
                        w_state_nxt = S_IF_DROP;
                    end
                end
            end
            S_MEM_ACC: begin
                if (m_ack) begin
                    w_state_nxt     = S_IDLE;
                    w_m_req_nxt     = 1'b0;
                    w_mem_ready_nxt = 1'b1;
                    w_mem_rdata_nxt = m_rdata;
                end else if (w_timeout) begin
                    w_state_nxt     = S_IDLE;
                    w_m_req_nxt     = 1'b0;
                    w_bus_err_nxt   = 1'b1;
                    w_mem_ready_nxt = 1'b1;
                    w_mem_rdata_nxt = '0;
                end else begin
                    w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                end
            end
            S_IF_DROP: begin
                // Squashed fetch: let the memory finish, then discard its data.
                if (m_ack) begin
                    w_state_nxt = S_IDLE;
                    w_m_req_nxt = 1'b0;
                end else if (w_timeout) begin
                    w_state_nxt   = S_IDLE;
                    w_m_req_nxt   = 1'b0;
                    w_bus_err_nxt = 1'b1;
                end else begin
                    w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_m_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_req     <= 1'b0;
            r_m_we      <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_if_ready  <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_ready <= 1'b0;
            r_mem_rdata <= '0;
            r_bus_err   <= 1'b0;
            r_tcnt      <= '0;
        end else begin
            r_m_req     <= w_m_req_nxt;
            r_m_we      <= w_m_we_nxt;
            r_m_addr    <= w_m_addr_nxt;
            r_m_wdata   <= w_m_wdata_nxt;
            r_if_ready  <= w_if_ready_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_mem_ready <= w_mem_ready_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_tcnt      <= w_tcnt_nxt;
        end
    end

    assign m_req      = r_m_req;
    assign m_we       = r_m_we;
    assign m_addr     = r_m_addr;
    assign m_wdata    = r_m_wdata;
    assign if_ready   = r_if_ready;
    assign if_rdata   = r_if_rdata;
    assign mem_ready  = r_mem_ready;
    assign mem_rdata  = r_mem_rdata;
    assign bus_err    = r_bus_err;
    assign if_freeze  = if_req & ~r_if_ready;
    assign mem_freeze = mem_req & ~r_mem_ready;

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_if_cnt;
    logic [31:0] r_stat_mem_cnt;
    logic [31:0] r_stat_stall_cnt;

    // Saturating counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_if_cnt    <= '0;
            r_stat_mem_cnt   <= '0;
            r_stat_stall_cnt <= '0;
        end else begin
            if (r_if_ready && (r_stat_if_cnt != '1)) begin
                r_stat_if_cnt <= r_stat_if_cnt + 32'd1;
            end
            if (r_mem_ready && (r_stat_mem_cnt != '1)) begin
                r_stat_mem_cnt <= r_stat_mem_cnt + 32'd1;
            end
            if (if_freeze && (r_stat_stall_cnt != '1)) begin
                r_stat_stall_cnt <= r_stat_stall_cnt + 32'd1;
            end
        end
    end

    assign stat_if_cnt    = r_stat_if_cnt;
    assign stat_mem_cnt   = r_stat_mem_cnt;
    assign stat_stall_cnt = r_stat_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand sequences and random transactions vs. a transaction-level model.
// Stats counters are checked when ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_freeze;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_freeze;
    logic        bus_err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
`ifdef ARB_STATS_EN
    logic [31:0] stat_if_cnt;
    logic [31:0] stat_mem_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_taken (branch_taken),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_ready     (if_ready),
        .if_freeze    (if_freeze),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .mem_freeze   (mem_freeze),
        .bus_err      (bus_err),
`ifdef ARB_STATS_EN
        .stat_if_cnt    (stat_if_cnt),
        .stat_mem_cnt   (stat_mem_cnt),
        .stat_stall_cnt (stat_stall_cnt),
`endif
        .m_req        (m_req),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_rdata      (m_rdata),
        .m_ack        (m_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] new_addr;
        int          n_ack;
        int          br_at;
        int          exp_end;
        bit          exp_ready;
        logic [31:0] exp_rdata;
        bit          exp_berr;
    } txn_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input bit is_mem, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic [31:0] new_addr, input int n_ack, input int br_at,
                                input int exp_end, input bit exp_ready,
                                input logic [31:0] exp_rdata, input bit exp_berr);
        txn_t t;
        t.is_mem = is_mem; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        t.new_addr = new_addr; t.n_ack = n_ack; t.br_at = br_at;
        t.exp_end = exp_end; t.exp_ready = exp_ready; t.exp_rdata = exp_rdata; t.exp_berr = exp_berr;
        return t;
    endfunction

    // Reference outcome of one isolated access, from the protocol rules alone.
    function automatic txn_t model(input txn_t t);
        txn_t r;
        bit   tmo;
        r = t;
        tmo         = (t.n_ack >= TMO);
        r.exp_end   = tmo ? TMO + 1 : t.n_ack + 2;
        r.exp_berr  = tmo;
        r.exp_ready = t.is_mem || !(t.br_at >= 1 && t.br_at < r.exp_end);
        r.exp_rdata = tmo ? 32'h0 : t.rdata;
        return r;
    endfunction

    // One access from an idle arbiter; a squashed fetch is followed by the refetch of new_addr.
    task automatic do_txn(input txn_t t);
        bit          refetch;
        int          e;
        int          last;
        bit          exp_rdy;
        logic [31:0] exp_addr;
        e       = t.exp_end;
        refetch = !t.is_mem && !t.exp_ready;
        last    = refetch ? e + 2 : e;
        for (int c = 0; c <= last; c++) begin
            if (t.is_mem) begin
                mem_req = 1'b1; mem_we = t.we; mem_addr = t.addr; mem_wdata = t.wdata;
            end else begin
                if_req  = 1'b1;
                if_addr = (refetch && c >= t.br_at) ? t.new_addr : t.addr;
            end
            branch_taken = (c == t.br_at) && (c <= e);
            m_ack = (c >= 1 && c == 1 + t.n_ack && c < e) || (refetch && c == e + 1);
            if (m_ack) m_rdata = (c == e + 1) ? ~t.rdata : t.rdata;
            else       m_rdata = $urandom;
            @(negedge clk);
            if (c == 0 || c == e || c == e + 2) begin
                chk("m_req_idle", 32'(m_req), 32'd0);
            end else begin
                exp_addr = (c > e) ? t.new_addr : t.addr;
                chk("m_req_held", 32'(m_req), 32'd1);
                chk("m_addr", m_addr, exp_addr);
                chk("m_we", 32'(m_we), 32'(t.is_mem && c < e ? t.we : 1'b0));
                if (t.is_mem) chk("m_wdata", m_wdata, t.wdata);
            end
            exp_rdy = (c == e && t.exp_ready) || (c == e + 2 && refetch);
            chk("bus_err", 32'(bus_err), 32'(c == e && t.exp_berr));
            if (t.is_mem) begin
                chk("mem_ready", 32'(mem_ready), 32'(exp_rdy));
                chk("if_ready_other", 32'(if_ready), 32'd0);
                chk("mem_freeze", 32'(mem_freeze), 32'(!exp_rdy));
                if (exp_rdy) chk("mem_rdata", mem_rdata, t.exp_rdata);
            end else begin
                chk("if_ready", 32'(if_ready), 32'(exp_rdy));
                chk("mem_ready_other", 32'(mem_ready), 32'd0);
                chk("if_freeze", 32'(if_freeze), 32'(!exp_rdy));
                if (exp_rdy) chk("if_rdata", if_rdata, (c == e) ? t.exp_rdata : ~t.rdata);
            end
            @(posedge clk); #1;
        end
        if_req = 1'b0; mem_req = 1'b0; branch_taken = 1'b0; m_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    txn_t vec[10];
    txn_t rt;

    initial begin
        rst = 1'b1; branch_taken = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0;
        mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; m_rdata = '0; m_ack = 1'b0;

        vec[0] = mk(0, 0, 32'h100, 0, 32'hE3A00001, 0,          2, -1, 4, 1, 32'hE3A00001, 0);
        vec[1] = mk(0, 0, 32'h104, 0, 32'h11112222, 32'h200,    3,  2, 5, 0, 32'h0,        0);
        vec[2] = mk(1, 0, 32'h300, 0, 32'h99999999, 0,          9, -1, 5, 1, 32'h0,        1);
        vec[3] = mk(1, 1, 32'h400, 32'hAA, 32'h5A5A5A5A, 0,     0, -1, 2, 1, 32'h5A5A5A5A, 0);
        vec[4] = mk(0, 0, 32'h108, 0, 32'hCAFEF00D, 0,          3, -1, 5, 1, 32'hCAFEF00D, 0);
        vec[5] = mk(0, 0, 32'h10C, 0, 32'h33334444, 32'h220,    9,  3, 5, 0, 32'h0,        1);
        vec[6] = mk(0, 0, 32'h110, 0, 32'h0BADBEEF, 0,          1,  0, 3, 1, 32'h0BADBEEF, 0);
        vec[7] = mk(0, 0, 32'h114, 0, 32'h55556666, 32'h240,    1,  2, 3, 0, 32'h0,        0);
        vec[8] = mk(1, 0, 32'h500, 0, 32'h12345678, 0,          2,  1, 4, 1, 32'h12345678, 0);
        vec[9] = mk(0, 0, 32'h118, 0, 32'h87654321, 0,          0,  2, 2, 1, 32'h87654321, 0);

        #2 rst = 1'b0;
        #1;
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_we", 32'(m_we), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) do_txn(vec[i]);

        // Simultaneous requests: MEM first, IF only after mem_ready.
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h400; mem_wdata = 32'hAA;
        if_req = 1'b1; if_addr = 32'h180;
        @(negedge clk);
        chk("arb_c0_m_req", 32'(m_req), 32'd0);
        chk("arb_c0_if_freeze", 32'(if_freeze), 32'd1);
        chk("arb_c0_mem_freeze", 32'(mem_freeze), 32'd1);
        @(posedge clk); #1; m_ack = 1'b1; m_rdata = 32'h77;
        @(negedge clk);
        chk("arb_c1_m_we", 32'(m_we), 32'd1);
        chk("arb_c1_m_addr", m_addr, 32'h400);
        chk("arb_c1_m_wdata", m_wdata, 32'hAA);
        chk("arb_c1_if_freeze", 32'(if_freeze), 32'd1);
        @(posedge clk); #1; m_ack = 1'b0;
        @(negedge clk);
        chk("arb_c2_mem_ready", 32'(mem_ready), 32'd1);
        chk("arb_c2_m_req", 32'(m_req), 32'd0);
        chk("arb_c2_if_freeze", 32'(if_freeze), 32'd1);
        @(posedge clk); #1; mem_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hE3A00002;
        @(negedge clk);
        chk("arb_c3_m_req", 32'(m_req), 32'd1);
        chk("arb_c3_m_addr", m_addr, 32'h180);
        chk("arb_c3_m_we", 32'(m_we), 32'd0);
        chk("arb_c3_if_freeze", 32'(if_freeze), 32'd1);
        @(posedge clk); #1; m_ack = 1'b0;
        @(negedge clk);
        chk("arb_c4_if_ready", 32'(if_ready), 32'd1);
        chk("arb_c4_if_rdata", if_rdata, 32'hE3A00002);
        chk("arb_c4_if_freeze", 32'(if_freeze), 32'd0);
        @(posedge clk); #1; if_req = 1'b0;
        @(posedge clk); #1;

        // Spurious ack while idle.
        m_ack = 1'b1; m_rdata = 32'hDEADDEAD;
        @(negedge clk);
        chk("spur_m_req", 32'(m_req), 32'd0);
        @(posedge clk); #1; m_ack = 1'b0;
        @(negedge clk);
        chk("spur_if_ready", 32'(if_ready), 32'd0);
        chk("spur_mem_ready", 32'(mem_ready), 32'd0);
        chk("spur_bus_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            rt.is_mem   = 1'($urandom_range(0, 1));
            rt.we       = 1'($urandom_range(0, 1));
            rt.addr     = $urandom;
            rt.wdata    = $urandom;
            rt.rdata    = $urandom;
            rt.new_addr = $urandom;
            rt.n_ack    = int'($urandom_range(0, 6));
            rt.br_at    = int'($urandom_range(0, 7)) - 1;
            do_txn(model(rt));
        end

        // Asynchronous reset in the middle of an access.
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h600; mem_wdata = 32'h1234;
        @(posedge clk); #1;
        @(negedge clk);
        chk("arst_pre_m_req", 32'(m_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_m_req", 32'(m_req), 32'd0);
        chk("arst_m_we", 32'(m_we), 32'd0);
        chk("arst_m_addr", m_addr, 32'd0);
        chk("arst_mem_ready", 32'(mem_ready), 32'd0);
        chk("arst_if_ready", 32'(if_ready), 32'd0);
        chk("arst_bus_err", 32'(bus_err), 32'd0);
        mem_req = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Fresh counters: 3 fetches + 2 data accesses, each acked immediately.
        do_txn(model(mk(0, 0, 32'h700, 0, 32'hA1, 0, 0, -1, 0, 0, 0, 0)));
        do_txn(model(mk(1, 1, 32'h800, 32'h5, 32'hA2, 0, 0, -1, 0, 0, 0, 0)));
        do_txn(model(mk(0, 0, 32'h704, 0, 32'hA3, 0, 0, -1, 0, 0, 0, 0)));
        do_txn(model(mk(1, 0, 32'h804, 0, 32'hA4, 0, 0, -1, 0, 0, 0, 0)));
        do_txn(model(mk(0, 0, 32'h708, 0, 32'hA5, 0, 0, -1, 0, 0, 0, 0)));
        @(negedge clk);
`ifdef ARB_STATS_EN
        chk("stat_if_cnt", stat_if_cnt, 32'd3);
        chk("stat_mem_cnt", stat_mem_cnt, 32'd2);
        chk("stat_stall_cnt", stat_stall_cnt, 32'd6);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
